// File: rtl/voice_scheduler.sv
// Schedules offered notes onto parallel note_player voices and counts each voice down in beats.
// Optional build macro VOICE_STEAL_EN: when all voices are busy, overwrite the voice with the smallest remaining count.
module voice_scheduler #(
    parameter int unsigned VOICES     = 3,
    parameter int unsigned NOTE_WIDTH = 6,
    parameter int unsigned DUR_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic                  beat,
    input  logic                  note_req,
    input  logic [NOTE_WIDTH-1:0] note_in,
    input  logic [DUR_WIDTH-1:0]  duration_in,
    output logic                  note_ack,
    output logic [VOICES-1:0]     load_voice,
    output logic [NOTE_WIDTH-1:0] voice_note,
    output logic [DUR_WIDTH-1:0]  voice_duration,
    output logic [VOICES-1:0]     voice_active,
    output logic [VOICES-1:0]     voice_done,
    output logic                  all_idle
);

    localparam int unsigned VIDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_GUARD = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [VIDX_W-1:0]     sel_q, sel_d;
    logic [DUR_WIDTH-1:0]  rem_q [VOICES];
    logic [DUR_WIDTH-1:0]  rem_d [VOICES];
    logic                  note_ack_q, note_ack_d;
    logic [VOICES-1:0]     load_voice_q, load_voice_d;
    logic [NOTE_WIDTH-1:0] voice_note_q, voice_note_d;
    logic [DUR_WIDTH-1:0]  voice_duration_q, voice_duration_d;
    logic [VOICES-1:0]     voice_active_q, voice_active_d;
    logic [VOICES-1:0]     voice_done_q, voice_done_d;
    logic                  all_idle_q, all_idle_d;

    logic                  free_found;
    logic [VIDX_W-1:0]     free_idx;
    logic                  can_accept;
    logic [VIDX_W-1:0]     pick_idx;
    logic                  load_en;

    // Voice choice from registered counts: lowest-index free voice.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            if (!free_found && (rem_q[i] == '0)) begin
                free_found = 1'b1;
                free_idx   = VIDX_W'(i);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic [VIDX_W-1:0]    steal_idx;
    logic [DUR_WIDTH-1:0] steal_min;

    // Smallest remaining count wins; strict compare keeps ties on the lowest index.
    always_comb begin
        steal_idx = '0;
        steal_min = rem_q[0];
        for (int unsigned i = 1; i < VOICES; i++) begin
            if (rem_q[i] < steal_min) begin
                steal_min = rem_q[i];
                steal_idx = VIDX_W'(i);
            end
        end
        can_accept = 1'b1;
        pick_idx   = free_found ? free_idx : steal_idx;
    end
`else
    always_comb begin
        can_accept = free_found;
        pick_idx   = free_idx;
    end
`endif

    // Controller next-state, counter update and registered output values.
    always_comb begin
        state_d          = state_q;
        sel_d            = sel_q;
        note_ack_d       = 1'b0;
        load_voice_d     = '0;
        voice_note_d     = voice_note_q;
        voice_duration_d = voice_duration_q;
        voice_done_d     = '0;
        voice_active_d   = '0;
        load_en          = (state_q == S_LOAD) && (voice_duration_q != '0);

        // The voice being loaded takes its duration undecremented and never reports done.
        for (int unsigned i = 0; i < VOICES; i++) begin
            rem_d[i] = rem_q[i];
            if (load_en && (sel_q == VIDX_W'(i))) begin
                rem_d[i] = voice_duration_q;
            end else if (beat && play && (rem_q[i] != '0)) begin
                rem_d[i]        = rem_q[i] - DUR_WIDTH'(1);
                voice_done_d[i] = (rem_q[i] == DUR_WIDTH'(1));
            end
            voice_active_d[i] = (rem_d[i] != '0);
        end
        all_idle_d = (voice_active_d == '0);

        case (state_q)
            S_IDLE: begin
                if (note_req && play && can_accept) begin
                    state_d          = S_LOAD;
                    sel_d            = pick_idx;
                    voice_note_d     = note_in;
                    voice_duration_d = duration_in;
                    note_ack_d       = 1'b1;
                    if (duration_in != '0) begin
                        load_voice_d = VOICES'(1) << pick_idx;
                    end
                end
            end
            S_LOAD:  state_d = S_GUARD;
            S_GUARD: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            sel_q            <= '0;
            for (int unsigned i = 0; i < VOICES; i++) begin
                rem_q[i] <= '0;
            end
            note_ack_q       <= 1'b0;
            load_voice_q     <= '0;
            voice_note_q     <= '0;
            voice_duration_q <= '0;
            voice_active_q   <= '0;
            voice_done_q     <= '0;
            all_idle_q       <= 1'b1;
        end else begin
            state_q          <= state_d;
            sel_q            <= sel_d;
            for (int unsigned i = 0; i < VOICES; i++) begin
                rem_q[i] <= rem_d[i];
            end
            note_ack_q       <= note_ack_d;
            load_voice_q     <= load_voice_d;
            voice_note_q     <= voice_note_d;
            voice_duration_q <= voice_duration_d;
            voice_active_q   <= voice_active_d;
            voice_done_q     <= voice_done_d;
            all_idle_q       <= all_idle_d;
        end
    end

    assign note_ack       = note_ack_q;
    assign load_voice     = load_voice_q;
    assign voice_note     = voice_note_q;
    assign voice_duration = voice_duration_q;
    assign voice_active   = voice_active_q;
    assign voice_done     = voice_done_q;
    assign all_idle       = all_idle_q;

endmodule
